// File: rtl/lcd1602_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd1602_pkg                                                          |
// | Shared types and constants for the LCD1602 frame scheduler.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lcd1602_pkg;

    localparam int LINE_W = 128;
    localparam logic [LINE_W-1:0] BLANK_LINE = {16{8'h20}};

    typedef enum logic [2:0] {
        S_START     = 3'd0,
        S_WAIT_INIT = 3'd1,
        S_IDLE      = 3'd2,
        S_SHOW      = 3'd3,
        S_DWELL     = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lcd1602_rrarb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd1602_rrarb                                                        |
// | Two-way round-robin arbiter; grant outputs are combinational.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lcd1602_rrarb (
    input  logic       CLOCK,
    input  logic       RST_n,
    input  logic [1:0] iReq,
    input  logic       iAdv,
    output logic [1:0] oGnt,
    output logic       oIdx
);

    logic r_last;

    always_comb begin
        oIdx = 1'b0;
        case (iReq)
            2'b01:   oIdx = 1'b0;
            2'b10:   oIdx = 1'b1;
            2'b11:   oIdx = ~r_last;
            default: oIdx = 1'b0;
        endcase
        oGnt = (iReq == 2'b00) ? 2'b00 : (oIdx ? 2'b10 : 2'b01);
    end

    // Pointer starts as "B granted last" so the first tie goes to A.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            r_last <= 1'b1;
        end else if (iAdv) begin
            r_last <= oIdx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd1602_schedmod.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd1602_schedmod                                                     |
// | Frame scheduler sharing one LCD1602 function module between two      |
// | requesters; content swaps only at frame boundaries.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lcd1602_schedmod
    import lcd1602_pkg::*;
#(
    parameter int DWELL = 25_000_000
) (
    input  logic              CLOCK,
    input  logic              RST_n,
    input  logic [1:0]        iReq,
    input  logic [LINE_W-1:0] iLine1_A,
    input  logic [LINE_W-1:0] iLine2_A,
    input  logic [LINE_W-1:0] iLine1_B,
    input  logic [LINE_W-1:0] iLine2_B,
    output logic [1:0]        oAck,
    output logic              oCall,
    input  logic              iDone,
    output logic [LINE_W-1:0] oLine1,
    output logic [LINE_W-1:0] oLine2,
    output logic              oOwner,
    output logic              oInitDone
);

    localparam int CNT_W = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_call, w_call;
    logic [1:0]        r_ack, w_ack;
    logic              r_owner, w_owner;
    logic              r_init, w_init;
    logic [LINE_W-1:0] r_line1, w_line1;
    logic [LINE_W-1:0] r_line2, w_line2;
    logic              w_adv;
    logic [1:0]        w_gnt;
    logic              w_idx;

    lcd1602_rrarb u_arb (
        .CLOCK (CLOCK),
        .RST_n (RST_n),
        .iReq  (iReq),
        .iAdv  (w_adv),
        .oGnt  (w_gnt),
        .oIdx  (w_idx)
    );

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_call  <= 1'b0;
            r_ack   <= 2'b00;
            r_owner <= 1'b0;
            r_init  <= 1'b0;
            r_line1 <= BLANK_LINE;
            r_line2 <= BLANK_LINE;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_call  <= w_call;
            r_ack   <= w_ack;
            r_owner <= w_owner;
            r_init  <= w_init;
            r_line1 <= w_line1;
            r_line2 <= w_line2;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_call      = r_call;
        w_ack       = 2'b00;
        w_owner     = r_owner;
        w_init      = r_init;
        w_line1     = r_line1;
        w_line2     = r_line2;
        w_adv       = 1'b0;
        case (r_state)
            S_START: begin
                w_call      = 1'b1;
                w_state_nxt = S_WAIT_INIT;
            end
            S_WAIT_INIT: begin
                if (iDone) begin
                    w_init      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                // Loading on the iDone cycle keeps each row whole on the glass.
                if (iDone && (iReq != 2'b00)) begin
                    w_adv       = 1'b1;
                    w_owner     = w_idx;
                    w_line1     = (w_gnt == 2'b10) ? iLine1_B : iLine1_A;
                    w_line2     = (w_gnt == 2'b10) ? iLine2_B : iLine2_A;
                    w_state_nxt = S_SHOW;
                end
            end
            S_SHOW: begin
                if (iDone) begin
                    w_ack       = r_owner ? 2'b10 : 2'b01;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DWELL;
                end
            end
            S_DWELL: begin
                // Expiry wins over a coincident iDone; arbitration waits a frame.
                if (r_cnt >= c_cnt_last) begin
                    w_state_nxt = S_IDLE;
                end
                if (r_cnt != c_cnt_max) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_START;
            end
        endcase
    end

    assign oCall     = r_call;
    assign oAck      = r_ack;
    assign oOwner    = r_owner;
    assign oInitDone = r_init;
    assign oLine1    = r_line1;
    assign oLine2    = r_line2;

endmodule
`default_nettype wire

// File: tb/tb_lcd1602_schedmod.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lcd1602_schedmod                                                  |
// | Self-checking bench with a timestamp-based scheduler reference.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_lcd1602_schedmod;
    import lcd1602_pkg::*;

    localparam int DWELL = 20;
    localparam int FRAME = 50;
    localparam logic [LINE_W-1:0] SPACES = {16{8'h20}};

    logic              CLOCK = 1'b0;
    logic              RST_n = 1'b0;
    logic              iDone = 1'b0;
    logic              req_a = 1'b0;
    logic              req_b = 1'b0;
    logic [1:0]        iReq;
    logic [LINE_W-1:0] iLine1_A = '0, iLine2_A = '0, iLine1_B = '0, iLine2_B = '0;
    logic [1:0]        oAck;
    logic              oCall, oOwner, oInitDone;
    logic [LINE_W-1:0] oLine1, oLine2;

    int unsigned asserts = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;
    int unsigned inject_at = 0;
    int unsigned phase = 0;

    assign iReq = {req_b, req_a};

    lcd1602_schedmod #(.DWELL(DWELL)) dut (
        .CLOCK     (CLOCK),
        .RST_n     (RST_n),
        .iReq      (iReq),
        .iLine1_A  (iLine1_A),
        .iLine2_A  (iLine2_A),
        .iLine1_B  (iLine1_B),
        .iLine2_B  (iLine2_B),
        .oAck      (oAck),
        .oCall     (oCall),
        .iDone     (iDone),
        .oLine1    (oLine1),
        .oLine2    (oLine2),
        .oOwner    (oOwner),
        .oInitDone (oInitDone)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    // Function-module stand-in: iDone every FRAME cycles, plus an optional injected pulse.
    initial begin
        forever begin
            @(negedge CLOCK);
            if (!RST_n) begin
                phase = 0;
                iDone = 1'b0;
            end else begin
                phase = (phase == FRAME - 1) ? 0 : phase + 1;
                iDone = (phase == 0) || (inject_at != 0 && cyc + 1 == inject_at);
            end
        end
    end

    // Requesters drop their request during the ack cycle.
    initial begin
        forever begin
            @(negedge CLOCK);
            if (oAck[0]) req_a = 1'b0;
            if (oAck[1]) req_b = 1'b0;
        end
    end

    // Reference: times in edges since reset; arbitration allowed once idle_from is reached.
    logic              m_call = 1'b0, m_init = 1'b0, m_owner = 1'b0, m_last = 1'b1, m_pending = 1'b0;
    logic [1:0]        m_ack = 2'b00;
    logic [LINE_W-1:0] m_l1 = {16{8'h20}}, m_l2 = {16{8'h20}};
    int unsigned       m_e = 0, m_idle_from = 0;

    function automatic logic rr_pick(input logic [1:0] r, input logic last);
        if (r == 2'b11) return ~last;
        return r[1];
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    always @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            m_call <= 1'b0; m_init <= 1'b0; m_owner <= 1'b0; m_last <= 1'b1;
            m_pending <= 1'b0; m_ack <= 2'b00; m_l1 <= SPACES; m_l2 <= SPACES;
            m_e <= 0; m_idle_from <= 0;
        end else begin
            m_e   <= m_e + 1;
            m_ack <= 2'b00;
            if (!m_call) begin
                m_call <= 1'b1;
            end else if (!m_init) begin
                if (iDone) begin
                    m_init      <= 1'b1;
                    m_idle_from <= m_e + 2;
                end
            end else if (m_pending) begin
                if (iDone) begin
                    m_pending   <= 1'b0;
                    m_ack       <= m_owner ? 2'b10 : 2'b01;
                    m_idle_from <= m_e + 1 + DWELL + 1;
                end
            end else if ((m_e + 1 >= m_idle_from) && iDone && iReq != 2'b00) begin
                m_last    <= rr_pick(iReq, m_last);
                m_owner   <= rr_pick(iReq, m_last);
                m_pending <= 1'b1;
                m_l1      <= rr_pick(iReq, m_last) ? iLine1_B : iLine1_A;
                m_l2      <= rr_pick(iReq, m_last) ? iLine2_B : iLine2_A;
            end
        end
    end

    task automatic test_reset();
        RST_n = 1'b0;
        repeat (3) @(negedge CLOCK);
        asserts++;
        if ({oCall, oAck, oOwner, oInitDone} !== 5'b0)
            begin fails++; $display("FAIL reset_ctrl got=%b want=00000", {oCall, oAck, oOwner, oInitDone}); end
        asserts++;
        if (oLine1 !== SPACES || oLine2 !== SPACES)
            begin fails++; $display("FAIL reset_lines got=%h/%h want=%h", oLine1, oLine2, SPACES); end
        RST_n = 1'b1;
        #1;
        asserts++;
        if (oCall !== 1'b0) begin fails++; $display("FAIL call_release got=%b want=0", oCall); end
        @(negedge CLOCK);
        asserts++;
        if (oCall !== 1'b1) begin fails++; $display("FAIL call_rise got=%b want=1", oCall); end
        asserts++;
        if (oInitDone !== 1'b0) begin fails++; $display("FAIL init_early got=%b want=0", oInitDone); end
    endtask

    task automatic test_req_during_init();
        logic [LINE_W-1:0] h1, h2;
        int unsigned load_cyc, ack_cyc;
        bit seen_init, done;
        h1 = "HELLO WORLD     ";
        h2 = "LCD1602 SCHED   ";
        iLine1_A = h1; iLine2_A = h2; req_a = 1'b1;
        seen_init = 0; done = 0; load_cyc = 0; ack_cyc = 0;
        for (int i = 0; i < 6 * FRAME && !done; i++) begin
            @(negedge CLOCK);
            asserts++;
            if ({oCall, oInitDone, oOwner, oAck, oLine1, oLine2} !== {m_call, m_init, m_owner, m_ack, m_l1, m_l2})
                begin fails++; $display("FAIL init_model got=%h want=%h", {oCall, oInitDone, oOwner, oAck, oLine1, oLine2}, {m_call, m_init, m_owner, m_ack, m_l1, m_l2}); end
            if (oInitDone && !seen_init) begin
                seen_init = 1;
                asserts++;
                if (oLine1 !== SPACES) begin fails++; $display("FAIL init_noload got=%h want=%h", oLine1, SPACES); end
            end
            if (load_cyc == 0 && oLine1 === h1) load_cyc = cyc;
            if (oAck != 2'b00) begin ack_cyc = cyc; done = 1; end
        end
        asserts++;
        if (!done) begin fails++; $display("FAIL init_ack_timeout got=none want=01"); end
        else begin
            asserts++;
            if (oAck !== 2'b01 || oOwner !== 1'b0 || oLine2 !== h2)
                begin fails++; $display("FAIL init_ack got=%b/%b want=01/0", oAck, oOwner); end
            asserts++;
            if (ack_cyc - load_cyc != FRAME)
                begin fails++; $display("FAIL load_to_ack got=%0d want=%0d", ack_cyc - load_cyc, FRAME); end
        end
    endtask

    task automatic test_req_during_dwell();
        logic [LINE_W-1:0] a1, b1;
        int unsigned ack_a, load_b;
        bit done;
        @(negedge CLOCK);
        a1 = rand_line(); b1 = rand_line();
        iLine1_A = a1; iLine2_A = rand_line(); req_a = 1'b1;
        done = 0; ack_a = 0; load_b = 0;
        for (int i = 0; i < 8 * FRAME && !done; i++) begin
            @(negedge CLOCK);
            asserts++;
            if ({oCall, oInitDone, oOwner, oAck, oLine1, oLine2} !== {m_call, m_init, m_owner, m_ack, m_l1, m_l2})
                begin fails++; $display("FAIL dwell_model got=%h want=%h", {oCall, oInitDone, oOwner, oAck, oLine1, oLine2}, {m_call, m_init, m_owner, m_ack, m_l1, m_l2}); end
            if (oAck == 2'b01 && ack_a == 0) begin
                ack_a = cyc;
                iLine1_B = b1; iLine2_B = rand_line(); req_b = 1'b1;
            end
            if (ack_a != 0 && load_b == 0 && oLine1 === b1) load_b = cyc;
            if (ack_a != 0 && load_b == 0 && oAck == 2'b10) begin
                asserts++; fails++; $display("FAIL dwell_early_ack got=10 want=00");
            end
            if (oAck == 2'b10) done = 1;
        end
        asserts++;
        if (!done) begin fails++; $display("FAIL dwell_timeout got=none want=10"); end
        asserts++;
        if (load_b < ack_a + DWELL + 1)
            begin fails++; $display("FAIL dwell_hold got=%0d want>=%0d", load_b, ack_a + DWELL + 1); end
    endtask

    task automatic test_tie();
        logic [1:0] first_ack, second_ack;
        @(negedge CLOCK);
        repeat (DWELL + 5) @(negedge CLOCK);
        iLine1_A = rand_line(); iLine2_A = rand_line();
        iLine1_B = rand_line(); iLine2_B = rand_line();
        req_a = 1'b1; req_b = 1'b1;
        first_ack = 2'b00; second_ack = 2'b00;
        for (int i = 0; i < 8 * FRAME && second_ack == 2'b00; i++) begin
            @(negedge CLOCK);
            asserts++;
            if ({oCall, oInitDone, oOwner, oAck, oLine1, oLine2} !== {m_call, m_init, m_owner, m_ack, m_l1, m_l2})
                begin fails++; $display("FAIL tie_model got=%h want=%h", {oCall, oInitDone, oOwner, oAck, oLine1, oLine2}, {m_call, m_init, m_owner, m_ack, m_l1, m_l2}); end
            if (oAck != 2'b00) begin
                if (first_ack == 2'b00) first_ack = oAck;
                else second_ack = oAck;
            end
        end
        asserts++;
        if (first_ack !== 2'b01) begin fails++; $display("FAIL tie_first got=%b want=01", first_ack); end
        asserts++;
        if (second_ack !== 2'b10) begin fails++; $display("FAIL tie_second got=%b want=10", second_ack); end
        asserts++;
        if (oOwner !== 1'b1 || oLine1 !== iLine1_B)
            begin fails++; $display("FAIL tie_owner got=%b want=1", oOwner); end
    endtask

    task automatic test_expiry_coincide();
        logic [LINE_W-1:0] a1, b1;
        int unsigned ack_a, load_b;
        bit done;
        @(negedge CLOCK);
        a1 = rand_line(); b1 = rand_line();
        iLine1_A = a1; iLine2_A = rand_line(); req_a = 1'b1;
        done = 0; ack_a = 0; load_b = 0;
        for (int i = 0; i < 8 * FRAME && !done; i++) begin
            @(negedge CLOCK);
            asserts++;
            if ({oCall, oInitDone, oOwner, oAck, oLine1, oLine2} !== {m_call, m_init, m_owner, m_ack, m_l1, m_l2})
                begin fails++; $display("FAIL expiry_model got=%h want=%h", {oCall, oInitDone, oOwner, oAck, oLine1, oLine2}, {m_call, m_init, m_owner, m_ack, m_l1, m_l2}); end
            if (oAck == 2'b01 && ack_a == 0) begin
                ack_a = cyc;
                inject_at = cyc + DWELL;
                iLine1_B = b1; iLine2_B = rand_line(); req_b = 1'b1;
            end
            if (ack_a != 0 && cyc == ack_a + DWELL) begin
                asserts++;
                if (oLine1 !== a1) begin fails++; $display("FAIL expiry_noload got=%h want=%h", oLine1, a1); end
            end
            if (ack_a != 0 && load_b == 0 && oLine1 === b1) load_b = cyc;
            if (oAck == 2'b10) done = 1;
        end
        inject_at = 0;
        asserts++;
        if (!done) begin fails++; $display("FAIL expiry_timeout got=none want=10"); end
        asserts++;
        if (load_b != ack_a + FRAME)
            begin fails++; $display("FAIL expiry_load got=%0d want=%0d", load_b, ack_a + FRAME); end
    endtask

    task automatic test_reset_in_show();
        logic [LINE_W-1:0] a1;
        bit loaded, acked;
        @(negedge CLOCK);
        a1 = rand_line();
        iLine1_A = a1; iLine2_A = rand_line(); req_a = 1'b1;
        loaded = 0;
        for (int i = 0; i < 4 * FRAME && !loaded; i++) begin
            @(negedge CLOCK);
            if (oLine1 === a1) loaded = 1;
        end
        asserts++;
        if (!loaded) begin fails++; $display("FAIL show_load_timeout got=%h want=%h", oLine1, a1); end
        repeat (10) @(negedge CLOCK);
        RST_n = 1'b0;
        req_a = 1'b0;
        #1;
        asserts++;
        if ({oCall, oAck, oOwner, oInitDone} !== 5'b0 || oLine1 !== SPACES || oLine2 !== SPACES)
            begin fails++; $display("FAIL show_reset got=%b/%h want=00000/%h", {oCall, oAck, oOwner, oInitDone}, oLine1, SPACES); end
        repeat (3) @(negedge CLOCK);
        RST_n = 1'b1;
        acked = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge CLOCK);
            asserts++;
            if ({oCall, oInitDone, oOwner, oAck, oLine1, oLine2} !== {m_call, m_init, m_owner, m_ack, m_l1, m_l2})
                begin fails++; $display("FAIL reinit_model got=%h want=%h", {oCall, oInitDone, oOwner, oAck, oLine1, oLine2}, {m_call, m_init, m_owner, m_ack, m_l1, m_l2}); end
            if (oAck != 2'b00) acked = 1;
        end
        asserts++;
        if (acked) begin fails++; $display("FAIL show_reset_ack got=1 want=0"); end
        asserts++;
        if (oInitDone !== 1'b1) begin fails++; $display("FAIL reinit got=%b want=1", oInitDone); end
    endtask

    task automatic test_random();
        int unsigned acks;
        acks = 0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge CLOCK);
            asserts++;
            if ({oCall, oInitDone, oOwner, oAck, oLine1, oLine2} !== {m_call, m_init, m_owner, m_ack, m_l1, m_l2})
                begin fails++; $display("FAIL random_model got=%h want=%h", {oCall, oInitDone, oOwner, oAck, oLine1, oLine2}, {m_call, m_init, m_owner, m_ack, m_l1, m_l2}); end
            if (oAck != 2'b00) acks++;
            if (!req_a && !oAck[0] && $urandom_range(0, 19) == 0) begin
                iLine1_A = rand_line(); iLine2_A = rand_line(); req_a = 1'b1;
            end
            if (!req_b && !oAck[1] && $urandom_range(0, 19) == 0) begin
                iLine1_B = rand_line(); iLine2_B = rand_line(); req_b = 1'b1;
            end
        end
        asserts++;
        if (acks < 8) begin fails++; $display("FAIL random_progress got=%0d want>=8", acks); end
    endtask

    initial begin
        test_reset();
        test_req_during_init();
        test_req_during_dwell();
        test_tie();
        test_expiry_coincide();
        test_reset_in_show();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
`default_nettype wire
